// File: rtl/trap_pkg.sv
// trap_pkg: shared state encoding, interrupt cause codes and machine CSR addresses
package trap_pkg;
   typedef enum logic [2:0] {IDLE, FLUSH, SAVE, VECTOR, MRET} state_t;
   localparam logic [4:0] CAUSE_SW = 5'd3;
   localparam logic [4:0] CAUSE_TIMER = 5'd7;
   localparam logic [4:0] CAUSE_EXT = 5'd11;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE = 12'h304;
   localparam logic [11:0] CSR_MEPC = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_MIP = 12'h344;
   localparam logic [11:0] CSR_MTVEC = 12'h305;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: picks the highest-priority pending interrupt (ext > sw > timer)
module irq_prio_enc
   import trap_pkg::*;
(
   input  logic [31:0] pending,
   output logic        valid,
   output logic [4:0]  code
);
   // only bits 3/7/11 can ever be set, so any set bit means a valid request
   always_comb begin
      valid = |pending;
      code = pending[11] ? CAUSE_EXT : pending[3] ? CAUSE_SW : pending[7] ? CAUSE_TIMER : 5'd0;
   end
endmodule

// File: rtl/trap_controller.sv
// trap_controller: machine-mode interrupt entry and MRET sequencing for the pipeline
module trap_controller
   import trap_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        irq_sw,
   input  logic        irq_timer,
   input  logic        irq_ext,
   input  logic        mstatus_mie,
   input  logic [31:0] mie,
   input  logic        inst_valid,
   input  logic        is_mret,
   input  logic [31:0] pc_ex,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc_in,
   output logic [31:0] mip,
   output logic        stall,
   output logic        flush,
   output logic        mepc_we,
   output logic        mcause_we,
   output logic [31:0] mepc_wdata,
   output logic [31:0] mcause_wdata,
   output logic        mstatus_trap,
   output logic        mstatus_mret,
   output logic        pc_redirect,
   output logic [31:0] redirect_pc
);
   state_t      state, next;
   logic [31:0] cap_pc, pending, base;
   logic [4:0]  cap_code, irq_code;
   logic        irq_valid, take;

   assign pending = mip & mie & {32{mstatus_mie}};
   assign base = {mtvec[31:2], 2'b00};
   assign take = state == IDLE && inst_valid && !is_mret && irq_valid;

   irq_prio_enc u_enc (
      .pending(pending),
      .valid(irq_valid),
      .code(irq_code)
   );

   // state register, pending-bit sampling and capture of the trapping PC/cause
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         mip <= '0;
         cap_pc <= '0;
         cap_code <= '0;
      end else begin
         state <= next;
         mip <= {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
         if (take) begin
            cap_pc <= pc_ex;
            cap_code <= irq_code;
         end
      end
   end

   // next state and per-state strobes; every output idles at zero
   always_comb begin
      next = state;
      stall = 1'b0;
      flush = 1'b0;
      mepc_we = 1'b0;
      mcause_we = 1'b0;
      mepc_wdata = '0;
      mcause_wdata = '0;
      mstatus_trap = 1'b0;
      mstatus_mret = 1'b0;
      pc_redirect = 1'b0;
      redirect_pc = '0;
      case (state)
         IDLE: next = (inst_valid && is_mret) ? MRET : take ? FLUSH : IDLE;
         FLUSH: begin
            flush = 1'b1;
            stall = 1'b1;
            next = SAVE;
         end
         SAVE: begin
            mepc_we = 1'b1;
            mcause_we = 1'b1;
            mepc_wdata = cap_pc;
            mcause_wdata = {1'b1, 26'b0, cap_code};
            mstatus_trap = 1'b1;
            stall = 1'b1;
            next = VECTOR;
         end
         VECTOR: begin
            pc_redirect = 1'b1;
            stall = 1'b1;
            redirect_pc = (mtvec[1:0] == 2'b01) ? base + {25'b0, cap_code, 2'b00} : base;
            next = IDLE;
         end
         MRET: begin
            pc_redirect = 1'b1;
            flush = 1'b1;
            mstatus_mret = 1'b1;
            redirect_pc = mepc_in;
            next = IDLE;
         end
         default: next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: scoreboard bench for trap entry, MRET and reset abort
module tb_trap_controller;
   typedef struct packed {
      logic [31:0] cyc;
      logic [6:0]  strobes;
      logic [31:0] mepc_wdata;
      logic [31:0] mcause_wdata;
      logic [31:0] redirect_pc;
   } obs_t;

   localparam logic [6:0] S_FLUSH = 7'b1100000;
   localparam logic [6:0] S_SAVE = 7'b0111100;
   localparam logic [6:0] S_VECTOR = 7'b0100001;
   localparam logic [6:0] S_MRET = 7'b1000011;

   logic        clk, rst, irq_sw, irq_timer, irq_ext, mstatus_mie, inst_valid, is_mret;
   logic [31:0] mie, pc_ex, mtvec, mepc_in, mip, mepc_wdata, mcause_wdata, redirect_pc;
   logic        stall, flush, mepc_we, mcause_we, mstatus_trap, mstatus_mret, pc_redirect;
   logic [6:0]  strobes;
   int          cyc, tests, fails;
   obs_t        q[$];

   trap_controller dut (
      .clk(clk), .rst(rst), .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
      .mstatus_mie(mstatus_mie), .mie(mie), .inst_valid(inst_valid), .is_mret(is_mret),
      .pc_ex(pc_ex), .mtvec(mtvec), .mepc_in(mepc_in), .mip(mip), .stall(stall),
      .flush(flush), .mepc_we(mepc_we), .mcause_we(mcause_we), .mepc_wdata(mepc_wdata),
      .mcause_wdata(mcause_wdata), .mstatus_trap(mstatus_trap), .mstatus_mret(mstatus_mret),
      .pc_redirect(pc_redirect), .redirect_pc(redirect_pc)
   );

   assign strobes = {flush, stall, mepc_we, mcause_we, mstatus_trap, mstatus_mret, pc_redirect};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   function automatic obs_t mk(input logic [31:0] c, input logic [6:0] s, input logic [31:0] ep, ec, rp);
      return {c, s, ep, ec, rp};
   endfunction

   task automatic check(input string name, input logic [134:0] got, input logic [134:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // monitor: every non-idle output cycle must match the next scoreboard entry
   always @(negedge clk) begin
      if (!rst && |strobes) begin
         obs_t act;
         act = mk(cyc, strobes, mepc_wdata, mcause_wdata, redirect_pc);
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output got=%h", act);
         end else check("scoreboard", act, q.pop_front());
      end
   end

   task automatic drain();
      for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout got=%0d pending exp=0", q.size());
         q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic trap_seq(input logic [2:0] irq, input logic [31:0] mie_v, mtvec_v, pc,
                           input logic [4:0] code, input logic [31:0] vec, input bit abort);
      int c;
      @(negedge clk);
      mstatus_mie = 1'b1;
      mie = mie_v;
      mtvec = mtvec_v;
      pc_ex = pc;
      {irq_ext, irq_timer, irq_sw} = irq;
      inst_valid = 1'b1;
      is_mret = 1'b0;
      c = cyc;
      q.push_back(mk(c + 2, S_FLUSH, 0, 0, 0));
      q.push_back(mk(c + 3, S_SAVE, pc, {1'b1, 26'b0, code}, 0));
      if (!abort) q.push_back(mk(c + 4, S_VECTOR, 0, 0, vec));
      repeat (2) @(negedge clk);
      {irq_ext, irq_timer, irq_sw} = 3'b000;
      inst_valid = 1'b0;
      pc_ex = 32'hDEAD_BEEF;
      if (abort) begin
         @(negedge clk);
         #2 rst = 1'b1;
         #1 check("reset_outputs", {32'd0, strobes, mepc_wdata, mcause_wdata, redirect_pc}, '0);
         check("reset_mip", {103'd0, mip}, '0);
         @(negedge clk);
         #1 rst = 1'b0;
      end
      drain();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      {irq_sw, irq_timer, irq_ext, mstatus_mie, inst_valid, is_mret} = '0;
      mie = '0;
      pc_ex = '0;
      mtvec = '0;
      mepc_in = '0;
      #1 check("reset_outputs", {32'd0, strobes, mepc_wdata, mcause_wdata, redirect_pc}, '0);
      check("reset_mip", {103'd0, mip}, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // timer, direct mode
      trap_seq(3'b010, 32'h80, 32'h1000, 32'h100, 5'd7, 32'h1000, 0);
      // external, vectored mode: 0x1000 + 4*11
      trap_seq(3'b100, 32'h800, 32'h1001, 32'h200, 5'd11, 32'h102C, 0);
      // all three pending: external wins
      trap_seq(3'b111, 32'h888, 32'h1000, 32'h300, 5'd11, 32'h1000, 0);
      // software alone, mode 3 treated as direct
      trap_seq(3'b001, 32'h8, 32'h1003, 32'h400, 5'd3, 32'h1000, 0);
      // sw and timer together: sw wins, vectored
      trap_seq(3'b011, 32'h88, 32'h2001, 32'h500, 5'd3, 32'h200C, 0);
      // vectored target wraps past 2^32
      trap_seq(3'b100, 32'h800, 32'hFFFF_FFF1, 32'hFFFF_FFFC, 5'd11, 32'h1C, 0);
      // global enable off: no trap, mip still reflects requests
      @(negedge clk);
      mstatus_mie = 1'b0;
      mie = 32'h888;
      {irq_ext, irq_timer, irq_sw} = 3'b111;
      inst_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("mip_masked", {103'd0, mip}, {103'd0, 32'h888});
      {irq_ext, irq_timer, irq_sw} = 3'b000;
      inst_valid = 1'b0;
      drain();
      // MRET beats a pending timer interrupt
      @(negedge clk);
      mstatus_mie = 1'b1;
      mie = 32'h80;
      irq_timer = 1'b1;
      repeat (2) @(negedge clk);
      check("mip_timer", {103'd0, mip}, {103'd0, 32'h80});
      inst_valid = 1'b1;
      is_mret = 1'b1;
      mepc_in = 32'h204;
      q.push_back(mk(cyc + 1, S_MRET, 0, 0, 32'h204));
      @(negedge clk);
      inst_valid = 1'b0;
      is_mret = 1'b0;
      irq_timer = 1'b0;
      drain();
      // reset while in SAVE abandons the sequence
      trap_seq(3'b010, 32'h80, 32'h1000, 32'h600, 5'd7, 32'h1000, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: irq_sw, irq_timer, irq_ext  input  1 each  level interrupt requests.
REQ-004 SHALL have port: mstatus_mie  input  1  global machine interrupt enable (mstatus[3]).
REQ-005 SHALL have port: mie  input  32  per-source enables; bit3 sw, bit7 timer, bit11 ext.
REQ-006 SHALL have ports: inst_valid  input  1  execute stage holds a valid instruction; is_mret  input  1  execute instruction is MRET.
REQ-007 SHALL have ports: pc_ex  input  32  execute-stage PC; mtvec  input  32  trap vector, [1:0] mode; mepc_in  input  32  current mepc.
REQ-008 SHALL have ports: mip  output  32  registered pending bits (3/7/11, others 0); stall, flush  output  1  pipeline control.
REQ-009 SHALL have ports: mepc_we, mcause_we  output  1; mepc_wdata, mcause_wdata  output  32  CSR write-back to the CSR file.
REQ-010 SHALL have ports: mstatus_trap, mstatus_mret  output  1  one-cycle strobes (trap: MPIE<-MIE, MIE<-0; mret: MIE<-MPIE, MPIE<-1).
REQ-011 SHALL have ports: pc_redirect  output  1; redirect_pc  output  32  next-PC override to the PC mux.

Function
REQ-012 SHALL sample irq_* into mip each cycle (one-cycle latency); pending = mip & mie & {32{mstatus_mie}}.
REQ-013 SHALL implement FSM states IDLE, FLUSH, SAVE, VECTOR, MRET.
REQ-014 IDLE: SHALL go to FLUSH when pending!=0 and inst_valid and !is_mret, capturing pc_ex and cause code in the same edge.
REQ-015 Priority SHALL be ext (11) > sw (3) > timer (7); only the highest source is captured.
REQ-016 IDLE: SHALL go to MRET when inst_valid and is_mret; MRET SHALL win over a simultaneous pending interrupt.
REQ-017 FLUSH: flush=1, stall=1 for one cycle, then SAVE.
REQ-018 SAVE: mepc_we=1 with captured PC; mcause_we=1 with {1'b1, 26'b0, code[4:0]}; mstatus_trap=1; stall=1; then VECTOR.
REQ-019 VECTOR: pc_redirect=1, stall=1; redirect_pc = {mtvec[31:2],2'b00} if mode=0, that base + 4*code if mode=1; modes 2/3 SHALL be treated as 0; then IDLE.
REQ-020 MRET: pc_redirect=1, flush=1, mstatus_mret=1, redirect_pc=mepc_in, one cycle, then IDLE.
REQ-021 Interrupt recognised at edge N SHALL produce pc_redirect in cycle N+3; no new request SHALL be accepted outside IDLE.
REQ-022 Deassertion of irq_* after capture SHALL NOT abort the sequence; the captured code SHALL be used.
REQ-023 All strobes (we, mstatus_*, pc_redirect, flush) SHALL be zero in IDLE; no strobe SHALL assert longer than one cycle per sequence.
REQ-024 Address arithmetic SHALL be 32-bit, wrap modulo 2^32.

Reset
REQ-025 On rst: state=IDLE, mip=0, captured PC/code=0, all outputs 0, effective immediately and asynchronously.
REQ-026 Reset mid-sequence SHALL abandon it with no further CSR write or redirect.

Structure
REQ-027 Package trap_pkg SHALL hold the state enum, cause codes (3/7/11), CSR addresses 0x300/0x304/0x341/0x342/0x344/0x305.
REQ-028 Priority selection SHALL be sub-module irq_prio_enc (pending in, valid + 5-bit code out, combinational).

Verification
REQ-029 mstatus_mie=1, mie=0x80, irq_timer=1, pc_ex=0x100, mtvec=0x1000 -> mepc_wdata=0x100, mcause_wdata=0x80000007, redirect_pc=0x1000 at N+3.
REQ-030 Same with mtvec=0x1001 and irq_ext, mie=0x800 -> mcause 0x8000000B, redirect_pc=0x102C.
REQ-031 irq_ext+irq_timer+irq_sw all set, mie=0x888 -> code 11 captured; mstatus_mie=0 -> no trap, mip still 0x888.
REQ-032 is_mret=1 with irq_timer pending, mepc_in=0x204 -> MRET wins, redirect_pc=0x204, mstatus_mret=1, no mepc write.
REQ-033 rst asserted during SAVE -> mepc_we/mcause_we never asserted after reset, state IDLE, pc_redirect=0.
